// File: rtl/gb_timer.sv
`default_nettype none
// ============================================================================
// Module   : gb_timer
// Brief    : DMG timer block (DIV/TIMA/TMA/TAC) with the free-running system
//            counter, falling-edge tick detect and delayed TMA reload + IRQ.
// Revision : 1.0
// ============================================================================
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          OVF_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        wr_en_i,
    output logic [7:0]  data_o,
    output logic        hit_o,
    output logic        irq_timer_o,
    output logic [15:0] sys_cnt_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_RELOAD = 2'd2;

    localparam int               CNT_W    = (OVF_DELAY > 1) ? $clog2(OVF_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVF_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [15:0]      r_sys_cnt;
    logic [7:0]       r_tima;
    logic [7:0]       r_tma;
    logic [2:0]       r_tac;
    logic             r_prev_in;
    logic             r_irq;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [15:0] w_offset;
    logic        w_hit;
    logic        w_wr;
    logic        w_wr_div;
    logic        w_wr_tima;
    logic        w_wr_tma;
    logic        w_wr_tac;
    logic [7:0]  w_tma_next;
    logic        w_sel_bit;
    logic        w_in;
    logic        w_tick;
    logic        w_tima_ovf;
    logic [7:0]  w_tima_inc;

    assign w_offset   = addr_i - BASE_ADDR;
    assign w_hit      = (w_offset[15:2] == 14'd0);
    assign w_wr       = wr_en_i & w_hit;
    assign w_wr_div   = w_wr & (w_offset[1:0] == 2'd0);
    assign w_wr_tima  = w_wr & (w_offset[1:0] == 2'd1);
    assign w_wr_tma   = w_wr & (w_offset[1:0] == 2'd2);
    assign w_wr_tac   = w_wr & (w_offset[1:0] == 2'd3);
    assign w_tma_next = w_wr_tma ? data_i : r_tma;

    always_comb begin
        w_sel_bit = r_sys_cnt[9];
        case (r_tac[1:0])
            2'd1:    w_sel_bit = r_sys_cnt[3];
            2'd2:    w_sel_bit = r_sys_cnt[5];
            2'd3:    w_sel_bit = r_sys_cnt[7];
            default: w_sel_bit = r_sys_cnt[9];
        endcase
    end

    // Gating by the enable before edge-detect lets DIV/TAC writes produce a tick
    assign w_in       = r_tac[2] & w_sel_bit;
    assign w_tick     = r_prev_in & ~w_in;
    assign w_tima_ovf = (r_tima == 8'hFF);
    assign w_tima_inc = r_tima + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sys_cnt <= 16'd0;
            r_tma     <= 8'd0;
            r_tac     <= 3'd0;
            r_prev_in <= 1'b0;
        end else begin
            r_sys_cnt <= w_wr_div ? 16'd0 : r_sys_cnt + 16'd1;
            r_tma     <= w_tma_next;
            r_prev_in <= w_in;
            if (w_wr_tac) begin
                r_tac <= data_i[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tima  <= 8'd0;
            r_irq   <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_tima) begin
                        r_tima <= data_i;
                    end else if (w_tick) begin
                        if (w_tima_ovf) begin
                            r_tima  <= 8'd0;
                            r_state <= ST_DELAY;
                            r_cnt   <= '0;
                        end else begin
                            r_tima <= w_tima_inc;
                        end
                    end
                end
                ST_DELAY: begin
                    if (w_wr_tima) begin
                        r_tima  <= data_i;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_tima  <= w_tma_next;
                        r_irq   <= 1'b1;
                        r_state <= ST_RELOAD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_tick) begin
                            r_tima <= w_tima_inc;
                        end
                    end
                end
                ST_RELOAD: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                    end
                    // TIMA writes are dropped here; a TMA write lands in both
                    if (w_wr_tma) begin
                        r_tima <= data_i;
                    end else if (w_tick) begin
                        if (w_tima_ovf) begin
                            r_tima  <= 8'd0;
                            r_state <= ST_DELAY;
                            r_cnt   <= '0;
                        end else begin
                            r_tima <= w_tima_inc;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_o = 8'hFF;
        if (w_hit) begin
            case (w_offset[1:0])
                2'd0:    data_o = r_sys_cnt[15:8];
                2'd1:    data_o = r_tima;
                2'd2:    data_o = r_tma;
                default: data_o = {5'b11111, r_tac};
            endcase
        end
    end

    assign hit_o       = w_hit;
    assign irq_timer_o = r_irq;
    assign sys_cnt_o   = r_sys_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_timer
// Brief    : Scoreboard bench for gb_timer: behavioural model predicts every
//            cycle's outputs, plus directed scenarios with fixed expectations.
// Revision : 1.0
// ============================================================================
module tb_gb_timer;

    localparam logic [15:0] BASE   = 16'hFF04;
    localparam int          OVF    = 4;
    localparam logic [15:0] DIV_A  = BASE;
    localparam logic [15:0] TIMA_A = BASE + 16'd1;
    localparam logic [15:0] TMA_A  = BASE + 16'd2;
    localparam logic [15:0] TAC_A  = BASE + 16'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr_en;
    logic [7:0]  data_o;
    logic        hit_o;
    logic        irq;
    logic [15:0] sys_cnt;

    gb_timer #(.BASE_ADDR(BASE), .OVF_DELAY(OVF)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr_i     (addr),
        .data_i     (wdata),
        .wr_en_i    (wr_en),
        .data_o     (data_o),
        .hit_o      (hit_o),
        .irq_timer_o(irq),
        .sys_cnt_o  (sys_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  data;
        logic        hit;
        logic        irq;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_print = 0;

    // Reference model: pending reload countdown and reload window as integers
    logic [15:0] m_cnt;
    logic [2:0]  m_tac;
    logic [7:0]  m_tima;
    logic [7:0]  m_tma;
    logic        m_prev;
    logic        m_irq;
    int          m_pend;
    int          m_rwin;

    function automatic void m_reset();
        m_cnt  = 16'd0;
        m_tac  = 3'd0;
        m_tima = 8'd0;
        m_tma  = 8'd0;
        m_prev = 1'b0;
        m_irq  = 1'b0;
        m_pend = -1;
        m_rwin = 0;
    endfunction

    function automatic int m_off(input logic [15:0] a);
        return int'(a) - int'(BASE);
    endfunction

    function automatic logic m_hit(input logic [15:0] a);
        return (m_off(a) >= 0) && (m_off(a) <= 3);
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        case (m_off(a))
            0:       return m_cnt[15:8];
            1:       return m_tima;
            2:       return m_tma;
            3:       return {5'b11111, m_tac};
            default: return 8'hFF;
        endcase
    endfunction

    function automatic void m_step(input logic r, input logic [15:0] a,
                                   input logic [7:0] d, input logic we);
        int         off;
        int         bitpos;
        logic       wr;
        logic       in_now;
        logic       tick;
        logic [7:0] tma_n;
        if (r) begin
            m_reset();
            return;
        end
        off = m_off(a);
        wr  = we && m_hit(a);
        case (m_tac[1:0])
            2'd0:    bitpos = 9;
            2'd1:    bitpos = 3;
            2'd2:    bitpos = 5;
            default: bitpos = 7;
        endcase
        in_now = m_tac[2] & m_cnt[bitpos];
        tick   = m_prev & ~in_now;
        m_prev = in_now;
        m_irq  = 1'b0;
        tma_n  = (wr && off == 2) ? d : m_tma;
        if (m_pend >= 0) begin
            if (wr && off == 1) begin
                m_tima = d;
                m_pend = -1;
            end else if (m_pend == OVF - 1) begin
                m_tima = tma_n;
                m_irq  = 1'b1;
                m_pend = -1;
                m_rwin = OVF;
            end else begin
                m_pend++;
                if (tick) m_tima = m_tima + 8'd1;
            end
        end else if (m_rwin > 0) begin
            m_rwin--;
            if (wr && off == 2) begin
                m_tima = d;
            end else if (tick) begin
                if (m_tima == 8'hFF) begin
                    m_tima = 8'd0;
                    m_pend = 0;
                    m_rwin = 0;
                end else begin
                    m_tima = m_tima + 8'd1;
                end
            end
        end else begin
            if (wr && off == 1) begin
                m_tima = d;
            end else if (tick) begin
                if (m_tima == 8'hFF) begin
                    m_tima = 8'd0;
                    m_pend = 0;
                end else begin
                    m_tima = m_tima + 8'd1;
                end
            end
        end
        m_tma = tma_n;
        if (wr && off == 3) m_tac = d[2:0];
        m_cnt = (wr && off == 0) ? 16'd0 : m_cnt + 16'd1;
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic apply(input logic r, input logic [15:0] a, input logic [7:0] d, input logic we);
        exp_t e;
        reset = r;
        addr  = a;
        wdata = d;
        wr_en = we;
        e.data = m_read(a);
        e.hit  = m_hit(a);
        e.irq  = m_irq;
        e.cnt  = m_cnt;
        sb.push_back(e);
        m_step(r, a, d, we);
    endtask

    task automatic cyc(input logic r, input logic [15:0] a, input logic [7:0] d, input logic we);
        apply(r, a, d, we);
        @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string nm, input logic r, input logic [15:0] a, input logic [7:0] d,
                        input logic we, input logic [7:0] ed, input logic eh, input logic ei);
        apply(r, a, d, we);
        #2;
        check({nm, "_data"}, 32'(data_o), 32'(ed));
        check({nm, "_hit"},  32'(hit_o),  32'(eh));
        check({nm, "_irq"},  32'(irq),    32'(ei));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every clock the DUT presents a full output set
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (data_o !== e.data || hit_o !== e.hit || irq !== e.irq || sys_cnt !== e.cnt) begin
                    n_bad++;
                    if (n_print < 20) begin
                        n_print++;
                        $display("FAIL scoreboard t=%0t: got data=%h hit=%b irq=%b cnt=%h, expected data=%h hit=%b irq=%b cnt=%h",
                                 $time, data_o, hit_o, irq, sys_cnt, e.data, e.hit, e.irq, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  e;
        logic [15:0] ra;
        logic [7:0]  rd;
        logic        rw;
        logic        rr;
        reset = 1'b1;
        addr  = 16'h0000;
        wdata = 8'h00;
        wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_reset();

        // Scenario 1: basic overflow, delay, reload and IRQ
        cyc(0, TAC_A, 8'h05, 1);
        cyc(0, TMA_A, 8'h40, 1);
        cyc(0, TIMA_A, 8'hFE, 1);
        cyc(0, DIV_A, 8'hAA, 1);
        for (int j = 0; j <= 40; j++) begin
            e = (j < 17) ? 8'hFE : (j < 33) ? 8'hFF : (j < 37) ? 8'h00 : 8'h40;
            dchk("t1_tima", 0, TIMA_A, 8'h00, 0, e, 1, (j == 37));
        end

        // Scenario 2: TIMA write during the second delay clock cancels reload
        cyc(0, DIV_A, 8'h00, 1);
        for (int j = 0; j <= 40; j++) begin
            if (j == 0) begin
                dchk("t2_wr_ff", 0, TIMA_A, 8'hFF, 1, 8'h40, 1, 0);
            end else if (j == 18) begin
                dchk("t2_wr_delay", 0, TIMA_A, 8'h10, 1, 8'h00, 1, 0);
            end else begin
                e = (j < 17) ? 8'hFF : (j == 17) ? 8'h00 : (j < 33) ? 8'h10 : 8'h11;
                dchk("t2_tima", 0, TIMA_A, 8'h00, 0, e, 1, 0);
            end
        end

        // Scenario 3: writes during the reload window
        cyc(0, DIV_A, 8'h00, 1);
        for (int j = 0; j <= 41; j++) begin
            if (j == 0) begin
                dchk("t3_wr_ff", 0, TIMA_A, 8'hFF, 1, 8'h11, 1, 0);
            end else if (j == 21) begin
                dchk("t3_wr_tima_ign", 0, TIMA_A, 8'h99, 1, 8'h40, 1, 1);
            end else if (j == 23) begin
                dchk("t3_wr_tma", 0, TMA_A, 8'h77, 1, 8'h40, 1, 0);
            end else if (j == 41) begin
                dchk("t3_tma", 0, TMA_A, 8'h00, 0, 8'h77, 1, 0);
            end else begin
                e = (j < 17) ? 8'hFF : (j < 21) ? 8'h00 : (j < 24) ? 8'h40 : (j < 33) ? 8'h77 : 8'h78;
                dchk("t3_tima", 0, TIMA_A, 8'h00, 0, e, 1, 0);
            end
        end

        // Scenario 4: glitch ticks from a DIV write and from clearing the enable
        cyc(0, DIV_A, 8'h00, 1);
        for (int j = 0; j <= 1300; j++) begin
            case (j)
                0:    dchk("t4_wr_tac", 0, TAC_A, 8'h04, 1, 8'hFD, 1, 0);
                1:    dchk("t4_wr_tima", 0, TIMA_A, 8'h20, 1, 8'h79, 1, 0);
                599:  dchk("t4_pre", 0, TIMA_A, 8'h00, 0, 8'h20, 1, 0);
                600:  dchk("t4_wr_div", 0, DIV_A, 8'h55, 1, 8'h02, 1, 0);
                601:  dchk("t4_div_edge", 0, TIMA_A, 8'h00, 0, 8'h20, 1, 0);
                602:  dchk("t4_div_glitch", 0, TIMA_A, 8'h00, 0, 8'h21, 1, 0);
                1200: dchk("t4_wr_tac_off", 0, TAC_A, 8'h00, 1, 8'hFC, 1, 0);
                1201: dchk("t4_en_edge", 0, TIMA_A, 8'h00, 0, 8'h21, 1, 0);
                1202: dchk("t4_en_glitch", 0, TIMA_A, 8'h00, 0, 8'h22, 1, 0);
                1300: dchk("t4_disabled", 0, TIMA_A, 8'h00, 0, 8'h22, 1, 0);
                default: cyc(0, TIMA_A, 8'h00, 0);
            endcase
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ra = BASE - 16'd1 + 16'($urandom_range(0, 5));
            rd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom);
            rw = ($urandom_range(0, 3) == 0);
            if (ra == DIV_A && $urandom_range(0, 9) != 0) rw = 1'b0;
            rr = ($urandom_range(0, 499) == 0);
            cyc(rr, ra, rd, rw);
        end

        // Scenario 5: register read formats and DIV after a known count
        cyc(0, TAC_A, 8'hFD, 1);
        dchk("t5_tac_read", 0, TAC_A, 8'h00, 0, 8'hFD, 1, 0);
        dchk("t5_unmapped_hi", 0, 16'hFF08, 8'h00, 0, 8'hFF, 0, 0);
        dchk("t5_unmapped_lo", 0, 16'hFF03, 8'h00, 0, 8'hFF, 0, 0);
        cyc(1, TIMA_A, 8'h00, 0);
        for (int k = 0; k <= 16'h1234; k++) begin
            case (k)
                0:       dchk("t5_rst_tima", 0, TIMA_A, 8'h00, 0, 8'h00, 1, 0);
                1:       dchk("t5_rst_tac", 0, TAC_A, 8'h00, 0, 8'hF8, 1, 0);
                2:       dchk("t5_rst_tma", 0, TMA_A, 8'h00, 0, 8'h00, 1, 0);
                16'h1234: dchk("t5_div", 0, DIV_A, 8'h00, 0, 8'h12, 1, 0);
                default: cyc(0, TIMA_A, 8'h00, 0);
            endcase
        end

        // Scenario 6: reset during DELAY, then a full counter wrap
        cyc(0, TAC_A, 8'h05, 1);
        cyc(0, TIMA_A, 8'hFF, 1);
        cyc(0, DIV_A, 8'h00, 1);
        for (int j = 0; j <= 18; j++) begin
            if (j == 18) begin
                cyc(1, TIMA_A, 8'h00, 0);
            end else begin
                e = (j < 17) ? 8'hFF : 8'h00;
                dchk("t6_tima", 0, TIMA_A, 8'h00, 0, e, 1, 0);
            end
        end
        for (int k = 0; k <= 32'h10000; k++) begin
            if (k <= 8) begin
                dchk("t6_rst_noirq", 0, TIMA_A, 8'h00, 0, 8'h00, 1, 0);
            end else if (k == 9) begin
                dchk("t6_rst_tac", 0, TAC_A, 8'h00, 0, 8'hF8, 1, 0);
            end else if (k == 16'hFFFF) begin
                dchk("t6_div_top", 0, DIV_A, 8'h00, 0, 8'hFF, 1, 0);
            end else if (k == 32'h10000) begin
                apply(0, DIV_A, 8'h00, 0);
                #2;
                check("t6_wrap_cnt", 32'(sys_cnt), 32'h0);
                check("t6_wrap_div", 32'(data_o), 32'h0);
                @(posedge clk);
                #1;
            end else begin
                cyc(0, TIMA_A, 8'h00, 0);
            end
        end

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
